// File: rtl/sram_pkg.sv
// Shared types and constants for the async SRAM bridge.
// The FSM state enum, the halfword phase selects and the default strobe length.
package sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } sram_state_e;

  localparam logic PH_LO = 1'b0;
  localparam logic PH_HI = 1'b1;

  localparam int ACCESS_CYC_DEF = 2;

endpackage

// File: rtl/sram_dq_buf.sv
// Tristate driver and input capture register for the 16-bit SRAM data bus.
// din samples the bus on every rising edge; the controller decides which samples matter.
module sram_dq_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        drive,
  input  logic [15:0] dout,
  output logic [15:0] din,
  inout  wire  [15:0] dq
);

  assign dq = drive ? dout : 16'hzzzz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din <= '0;
    else        din <= dq;
  end

endmodule

// File: rtl/sram_ctrl.sv
// Bridges one 32-bit byte-masked load/store into one or two 16-bit async SRAM accesses.
// All SRAM pins come straight from flops that are loaded from the next-state decode.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ACCESS_CYC = ACCESS_CYC_DEF,
  parameter int SRAM_AW    = 18
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_req,
  output logic               o_ready,
  input  logic               i_wren,
  input  logic [31:0]        i_addr,
  input  logic [31:0]        i_wdata,
  input  logic [3:0]         i_bmask,
  output logic               o_ack,
  output logic [31:0]        o_rdata,
  output logic [SRAM_AW-1:0] o_sram_addr,
  inout  wire  [15:0]        io_sram_dq,
  output logic               o_sram_ce_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_we_n,
  output logic               o_sram_lb_n,
  output logic               o_sram_ub_n
);

  localparam int CW = $clog2(ACCESS_CYC + 1);
  localparam logic [CW-1:0] RD_LAST = CW'(ACCESS_CYC - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(ACCESS_CYC);

  sram_state_e          state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [SRAM_AW-2:0]   waddr_q, waddr_n;
  logic [31:0]          wdata_q, wdata_n;
  logic [3:0]           mask_q, mask_n;
  logic                 cap_lo, cap_hi, pend_lo, pend_hi;
  logic [31:0]          rd_q;
  logic [15:0]          din, dout_q, lo_keep, hi_keep;
  logic                 drive_q, accept;
  logic                 rd_n, wr_n, hi_n;
  logic                 unused_addr;

  assign accept      = i_req && (state == IDLE);
  assign o_ready     = (state == IDLE);
  assign o_ack       = (state == DONE);
  assign unused_addr = ^{i_addr[31:SRAM_AW+1], i_addr[1:0]};

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    waddr_n = waddr_q;
    wdata_n = wdata_q;
    mask_n  = mask_q;
    cap_lo  = 1'b0;
    cap_hi  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (i_req) begin
          waddr_n = i_addr[SRAM_AW:2];
          wdata_n = i_wdata;
          mask_n  = i_bmask;
          if (|i_bmask[1:0])      state_n = i_wren ? WR_LO : RD_LO;
          else if (|i_bmask[3:2]) state_n = i_wren ? WR_HI : RD_HI;
          else                    state_n = DONE;
        end
      end
      RD_LO: if (cnt == RD_LAST) begin
        cnt_n   = '0;
        cap_lo  = 1'b1;
        state_n = (|mask_q[3:2]) ? RD_HI : DONE;
      end
      WR_LO: if (cnt == WR_LAST) begin
        cnt_n   = '0;
        state_n = (|mask_q[3:2]) ? WR_HI : DONE;
      end
      RD_HI: if (cnt == RD_LAST) begin
        cnt_n   = '0;
        cap_hi  = 1'b1;
        state_n = DONE;
      end
      WR_HI: if (cnt == WR_LAST) begin
        cnt_n   = '0;
        state_n = DONE;
      end
      DONE: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    rd_n = (state_n == RD_LO) || (state_n == RD_HI);
    wr_n = (state_n == WR_LO) || (state_n == WR_HI);
    hi_n = (state_n == RD_HI) || (state_n == WR_HI);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      pend_lo <= 1'b0;
      pend_hi <= 1'b0;
      rd_q    <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      waddr_q <= waddr_n;
      wdata_q <= wdata_n;
      mask_q  <= mask_n;
      pend_lo <= cap_lo;
      pend_hi <= cap_hi;
      if (accept) begin
        rd_q <= '0;
      end else begin
        if (pend_lo) rd_q[15:0]  <= din & lo_keep;
        if (pend_hi) rd_q[31:16] <= din & hi_keep;
      end
    end
  end

  // we_n stays high in the first cycle of each write phase so address/data set up first.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_sram_ce_n <= 1'b1;
      o_sram_oe_n <= 1'b1;
      o_sram_we_n <= 1'b1;
      o_sram_lb_n <= 1'b1;
      o_sram_ub_n <= 1'b1;
      o_sram_addr <= '0;
      drive_q     <= 1'b0;
      dout_q      <= '0;
    end else begin
      o_sram_ce_n <= !(rd_n || wr_n);
      o_sram_oe_n <= !rd_n;
      o_sram_we_n <= !(wr_n && (cnt_n != '0));
      o_sram_lb_n <= !((rd_n || wr_n) && (hi_n ? mask_n[2] : mask_n[0]));
      o_sram_ub_n <= !((rd_n || wr_n) && (hi_n ? mask_n[3] : mask_n[1]));
      if (rd_n || wr_n) o_sram_addr <= {waddr_n, (hi_n ? PH_HI : PH_LO)};
      drive_q     <= wr_n;
      dout_q      <= hi_n ? wdata_n[31:16] : wdata_n[15:0];
    end
  end

  // The last sample of a read phase is visible one cycle later; bypass it so
  // o_rdata is already complete while o_ack is high.
  assign lo_keep = {{8{mask_q[1]}}, {8{mask_q[0]}}};
  assign hi_keep = {{8{mask_q[3]}}, {8{mask_q[2]}}};
  assign o_rdata = {(pend_hi ? (din & hi_keep) : rd_q[31:16]),
                    (pend_lo ? (din & lo_keep) : rd_q[15:0])};

  sram_dq_buf u_dq_buf (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .drive (drive_q),
    .dout  (dout_q),
    .din   (din),
    .dq    (io_sram_dq)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with ACCESS_CYC = 2 against a behavioural 256K x 16 SRAM.
// Outputs are sampled on the falling edge; cycle 1 is the cycle right after the accept edge.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic        ready;
  logic        wren;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  bmask;
  logic        ack;
  logic [31:0] rdata;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;

  int checks = 0;
  int errors = 0;

  logic [17:0] addrLog [0:31];
  logic [15:0] dqLog   [0:31];
  logic        weLog   [0:31];
  logic        oeLog   [0:31];
  logic        lbLog   [0:31];
  logic        ubLog   [0:31];
  logic        rdyLog  [0:31];
  logic        anyWeLow, anyOeLow, anyCeLow;
  int          cyc, firstAck, secondAck;
  logic [31:0] firstData;
  logic        gapCe, gapReady;

  always #5 clk = ~clk;

  sram_ctrl #(.ACCESS_CYC(2), .SRAM_AW(18)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_req       (req),
    .o_ready     (ready),
    .i_wren      (wren),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_bmask     (bmask),
    .o_ack       (ack),
    .o_rdata     (rdata),
    .o_sram_addr (sram_addr),
    .io_sram_dq  (sram_dq),
    .o_sram_ce_n (ce_n),
    .o_sram_oe_n (oe_n),
    .o_sram_we_n (we_n),
    .o_sram_lb_n (lb_n),
    .o_sram_ub_n (ub_n)
  );

  // Behavioural SRAM: drives the full halfword on reads, writes enabled bytes while we_n is low.
  logic [15:0] mem [0:(1<<18)-1];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;
  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
      if (!ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] m);
    @(negedge clk);
    req   = 1'b1;
    wren  = w;
    addr  = a;
    wdata = d;
    bmask = m;
  endtask

  // Waits for the accept edge, then logs pins each cycle until o_ack (bounded).
  task automatic waitAck(input int limit, output int ackCyc);
    ackCyc   = -1;
    anyWeLow = 1'b0;
    anyOeLow = 1'b0;
    anyCeLow = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      req        = 1'b0;
      addrLog[n] = sram_addr;
      dqLog[n]   = sram_dq;
      weLog[n]   = we_n;
      oeLog[n]   = oe_n;
      lbLog[n]   = lb_n;
      ubLog[n]   = ub_n;
      rdyLog[n]  = ready;
      if (!we_n) anyWeLow = 1'b1;
      if (!oe_n) anyOeLow = 1'b1;
      if (!ce_n) anyCeLow = 1'b1;
      if (ack) begin
        ackCyc = n;
        break;
      end
    end
  endtask

  initial begin
    rstn  = 1'b0;
    req   = 1'b0;
    wren  = 1'b0;
    addr  = '0;
    wdata = '0;
    bmask = '0;
    #12;
    checkOutput("reset ready", 32'(ready), 32'd1);
    checkOutput("reset ack", 32'(ack), 32'd0);
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    checkOutput("reset sram addr", 32'(sram_addr), 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Full-word store
    applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
    waitAck(20, cyc);
    checkOutput("st full ack cycle", 32'(cyc), 32'd7);
    checkOutput("st lo addr", 32'(addrLog[1]), 32'h8);
    checkOutput("st lo dq", 32'(dqLog[1]), 32'hBEEF);
    checkOutput("st lo setup we", 32'(weLog[1]), 32'd1);
    checkOutput("st lo we c2", 32'(weLog[2]), 32'd0);
    checkOutput("st lo we c3", 32'(weLog[3]), 32'd0);
    checkOutput("st lo lanes", {30'd0, lbLog[2], ubLog[2]}, 32'd0);
    checkOutput("st hi addr", 32'(addrLog[4]), 32'h9);
    checkOutput("st hi setup we", 32'(weLog[4]), 32'd1);
    checkOutput("st hi dq", 32'(dqLog[5]), 32'hDEAD);
    checkOutput("st oe never low", 32'(anyOeLow), 32'd0);
    checkOutput("st ready busy", 32'(rdyLog[3]), 32'd0);

    // Full-word load of the same word
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'b1111);
    waitAck(20, cyc);
    checkOutput("ld full ack cycle", 32'(cyc), 32'd5);
    checkOutput("ld full rdata", rdata, 32'hDEAD_BEEF);
    checkOutput("ld we never low", 32'(anyWeLow), 32'd0);
    checkOutput("ld lo oe", 32'(oeLog[1]), 32'd0);
    checkOutput("ld hi addr", 32'(addrLog[3]), 32'h9);
    @(negedge clk);
    checkOutput("ld ready after", 32'(ready), 32'd1);
    checkOutput("ld rdata held", rdata, 32'hDEAD_BEEF);

    // Single-byte store into lane 1
    applyStimulus(1'b1, 32'h0000_0010, 32'h0000_AB00, 4'b0010);
    waitAck(20, cyc);
    checkOutput("st b1 ack cycle", 32'(cyc), 32'd4);
    checkOutput("st b1 addr", 32'(addrLog[1]), 32'h8);
    checkOutput("st b1 lanes", {30'd0, lbLog[1], ubLog[1]}, 32'b10);
    checkOutput("st b1 dq", 32'(dqLog[2]), 32'hAB00);

    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'b1111);
    waitAck(20, cyc);
    checkOutput("ld merged ack cycle", 32'(cyc), 32'd5);
    checkOutput("ld merged rdata", rdata, 32'hDEAD_ABEF);

    // Single-byte load from lane 2: only the HI phase, other lanes zero
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'b0100);
    waitAck(20, cyc);
    checkOutput("ld b2 ack cycle", 32'(cyc), 32'd3);
    checkOutput("ld b2 rdata", rdata, 32'h00AD_0000);
    checkOutput("ld b2 addr", 32'(addrLog[1]), 32'h9);
    checkOutput("ld b2 lanes", {30'd0, lbLog[1], ubLog[1]}, 32'b01);

    // Empty mask: straight to DONE
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'b0000);
    waitAck(20, cyc);
    checkOutput("mask0 ack cycle", 32'(cyc), 32'd1);
    checkOutput("mask0 no ce", 32'(anyCeLow), 32'd0);
    checkOutput("mask0 rdata", rdata, 32'h0);
    @(negedge clk);
    checkOutput("mask0 ready after", 32'(ready), 32'd1);

    applyStimulus(1'b1, 32'h0000_0014, 32'h5678_1234, 4'b1111);
    waitAck(20, cyc);
    checkOutput("st second word ack", 32'(cyc), 32'd7);

    // Back-to-back loads with i_req held high
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'b1111);
    firstAck  = -1;
    secondAck = -1;
    firstData = '0;
    gapCe     = 1'b0;
    gapReady  = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (firstAck > 0 && n == firstAck + 1) begin
        gapCe    = ce_n;
        gapReady = ready;
      end
      if (ack && firstAck < 0) begin
        firstAck  = n;
        firstData = rdata;
        addr      = 32'h0000_0014;
      end else if (ack) begin
        secondAck = n;
        break;
      end
    end
    req = 1'b0;
    checkOutput("held first ack", 32'(firstAck), 32'd5);
    checkOutput("held first rdata", firstData, 32'hDEAD_ABEF);
    checkOutput("held gap ce", 32'(gapCe), 32'd1);
    checkOutput("held gap ready", 32'(gapReady), 32'd1);
    checkOutput("held second ack", 32'(secondAck), 32'd11);
    checkOutput("held second rdata", rdata, 32'h5678_1234);

    // Reset during the HI write phase
    applyStimulus(1'b1, 32'h0000_0018, 32'hCAFE_F00D, 4'b1111);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("pre-reset we", 32'(we_n), 32'd0);
    rstn = 1'b0;
    #1;
    checkOutput("mid reset strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    checkOutput("mid reset ack", 32'(ack), 32'd0);
    checkOutput("mid reset ready", 32'(ready), 32'd1);
    @(negedge clk);
    checkOutput("mid reset ack held", 32'(ack), 32'd0);
    rstn = 1'b1;

    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'b1111);
    waitAck(20, cyc);
    checkOutput("post reset ack cycle", 32'(cyc), 32'd5);
    checkOutput("post reset rdata", rdata, 32'hDEAD_ABEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Memory-side bridge directly downstream of the core's MEM stage (LSU).
- Converts one 32-bit, byte-masked load/store request into one or two 16-bit accesses on the board's asynchronous SRAM (IS61WV25616-class: 256K x 16, active-low CE/WE/OE/LB/UB).
- Uses a valid/ready request interface and a one-cycle completion pulse, so the pipeline can stall the MEM stage while the access completes.

Parameters:
- ACCESS_CYC, 2: cycles the read/write strobe is held per halfword phase; legal range ≥1.
- SRAM_AW, 18: SRAM halfword address width.

Ports:
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_req  in  1  request valid
- o_ready  out  1  controller idle; a request is accepted on a rising edge when i_req && o_ready
- i_wren  in  1  1 = store, 0 = load
- i_addr  in  32  byte address; bits [SRAM_AW:2] used, others ignored
- i_wdata  in  32  lane-aligned store data (byte n in bits [8n+7:8n])
- i_bmask  in  4  byte enables, lane-aligned
- o_ack  out  1  one-cycle completion pulse
- o_rdata  out  32  load data; valid while o_ack=1 and held until the next accept
- o_sram_addr  out  SRAM_AW  halfword address
- io_sram_dq  inout  16  SRAM data bus
- o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM strobes, active low

Behaviour:
- Reset (asynchronous, immediate):
  - All strobes = 1; o_sram_addr = 0; dq released (high-Z).
  - o_ready = 1, o_ack = 0, o_rdata = 0; FSM goes to IDLE.
- Reset mid-access: the access is aborted with no ack. The SRAM halfword being written may be corrupted; this is accepted.
- All SRAM outputs are registered, so no glitches reach the pins.
- Accept: the request is latched into internal registers (wren, word address, wdata, bmask); the cycle counter is cleared.
- Phase LO uses halfword address {addr[SRAM_AW:2], 1'b0} with lb_n = ~bmask[0], ub_n = ~bmask[1]. Phase HI uses {addr[SRAM_AW:2], 1'b1} with lb_n = ~bmask[2], ub_n = ~bmask[3].
- A phase whose two mask bits are both 0 is skipped entirely.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
  - From IDLE on accept, go to the first required phase. If bmask = 0, go directly to DONE.
  - After a LO phase, go to HI if required, else DONE.
  - DONE: o_ack = 1 for exactly one cycle, then IDLE.
- Read phase:
  - ce_n = 0, oe_n = 0, we_n = 1 for ACCESS_CYC cycles; dq high-Z.
  - dq is sampled on the final edge of the phase into the matching o_rdata half.
  - Byte lanes not enabled by the mask return 0.
- Write phase, ACCESS_CYC + 1 cycles:
  - Cycle 0 (setup): ce_n = 0, we_n = 1, oe_n = 1; address and data driven.
  - Next ACCESS_CYC cycles: we_n = 0.
  - dq is driven with the halfword for the whole phase and released in the cycle after the last write phase.
  - oe_n stays 1 throughout a write.
- Between phases, strobes may stay asserted; the address changes on the same edge that we_n rises.
- Latency from the accept edge to o_ack high:
  - Full-word read: 2·ACCESS_CYC + 1.
  - Full-word write: 2·(ACCESS_CYC + 1) + 1.
  - Single-phase access: the per-phase time + 1.
  - bmask = 0: 1.
- o_ready = 0 from the accept edge through DONE. i_req held high is ignored until the controller is back in IDLE, so the minimum request spacing is latency + 1.
- Counter width is $clog2(ACCESS_CYC + 1); wrap-around never occurs because the counter is cleared at each phase entry.

Decomposition:
- Package sram_pkg holds:
  - state enum sram_state_e
  - phase-select constants PH_LO/PH_HI
  - the default ACCESS_CYC
- One sub-module, sram_dq_buf, owns the tristate driver and the registered input capture:
  - inputs: drive enable, 16-bit out data
  - output: sampled 16-bit data
- The FSM and request registers live in sram_ctrl.

Test Plan:
- Store, addr 0x0000_0010, wdata 0xDEADBEEF, mask 4'b1111, ACCESS_CYC = 2:
  - LO phase: o_sram_addr = 0x00008, dq = 0xBEEF, lb_n = ub_n = 0, we_n low for 2 cycles.
  - HI phase: o_sram_addr = 0x00009, dq = 0xDEAD.
  - o_ack at cycle 7 after accept.
- Load from 0x0000_0010 after the store above → o_rdata = 0xDEADBEEF with o_ack at cycle 5; oe_n low and we_n high throughout; dq never driven.
- Store, wdata 0x0000_AB00, mask 4'b0010:
  - Only LO phase at 0x00008, with lb_n = 1, ub_n = 0.
  - A subsequent full load returns 0xDEADABEF.
- Request with mask 4'b0000 → no SRAM strobe asserted; o_ack exactly 1 cycle after accept; o_ready back to 1 the next cycle.
- i_req held high with two different loads queued → the second is accepted only when o_ready = 1 after DONE, with no overlap of phases.
- Assert i_rstn = 0 mid-WR_HI → all strobes = 1 and dq high-Z within the same cycle, no o_ack pulse; after release a full load completes normally.
